// File: rtl/lighting_system_if.sv
// Signal bundle between the time/user decoders, the lighting controller and the lamp/shade drivers.
interface lighting_system_if;
    logic [3:0]  tcode;
    logic [3:0]  ulight;
    logic [3:0]  lenght;
    logic [3:0]  wshade;
    logic [3:0]  lightnum;
    logic [15:0] lightstate;

    modport master (output tcode, ulight, lenght, input wshade, lightnum, lightstate);
    modport slave  (input tcode, ulight, lenght, output wshade, lightnum, lightstate);
endinterface

// File: rtl/lighting_system.sv
// Room lighting controller: decodes time of day into shade position and a capped,
// thermometer-coded lamp vector. All outputs registered, 1-cycle latency.
module lighting_system (
    input  logic              clk,
    input  logic              rst_n,
    lighting_system_if.slave  bus
);
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;

    logic [2:0]  tstate;
    logic [3:0]  req;
    logic [3:0]  wshade_d,     wshade_q;
    logic [3:0]  lightnum_d,   lightnum_q;
    logic [15:0] lightstate_d, lightstate_q;

    // Priority decode: highest set bit of tcode wins, all-zero means daylight.
    always_comb begin
        tstate = S4;
        if      (bus.tcode[3]) tstate = S3;
        else if (bus.tcode[2]) tstate = S2;
        else if (bus.tcode[1]) tstate = S1;
        else if (bus.tcode[0]) tstate = S0;
    end

    always_comb begin
        wshade_d = 4'b1111;
        req      = 4'd0;
        case (tstate)
            S0:      begin wshade_d = 4'b0000; req = bus.ulight;      end
            S1:      begin wshade_d = 4'b0100; req = bus.ulight;      end
            S2:      begin wshade_d = 4'b1000; req = bus.ulight >> 1; end
            S3:      begin wshade_d = 4'b1100; req = bus.ulight >> 2; end
            default: begin wshade_d = 4'b1111; req = 4'd0;            end
        endcase
        lightnum_d   = (req < bus.lenght) ? req : bus.lenght;
        // lightnum <= 15, so bit 15 of the thermometer can never be set.
        lightstate_d = (16'd1 << lightnum_d) - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wshade_q     <= 4'b0000;
            lightnum_q   <= 4'd0;
            lightstate_q <= 16'h0000;
        end else begin
            wshade_q     <= wshade_d;
            lightnum_q   <= lightnum_d;
            lightstate_q <= lightstate_d;
        end
    end

    assign bus.wshade     = wshade_q;
    assign bus.lightnum   = lightnum_q;
    assign bus.lightstate = lightstate_q;
endmodule

// File: tb/tb_lighting_system.sv
// Scoreboard bench for lighting_system: stimulus pushes expected results, a monitor
// pops and compares one cycle later.
module tb_lighting_system;
    logic clk;
    logic rst_n;
    lighting_system_if bus ();

    lighting_system dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  w;
        logic [3:0]  n;
        logic [15:0] s;
        logic [3:0]  len;
        string       name;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Independent reference: priority scan plus bit-by-bit thermometer.
    function automatic exp_t model(input logic [3:0] t, input logic [3:0] u, input logic [3:0] l);
        exp_t e;
        logic [3:0] r;
        if (t[3])      begin e.w = 4'hC; r = {2'b00, u[3:2]}; end
        else if (t[2]) begin e.w = 4'h8; r = {1'b0, u[3:1]};  end
        else if (t[1]) begin e.w = 4'h4; r = u;               end
        else if (t[0]) begin e.w = 4'h0; r = u;               end
        else           begin e.w = 4'hF; r = 4'd0;            end
        e.n = (l < r) ? l : r;
        e.s = 16'h0000;
        for (int i = 0; i < 16; i++) if (i < int'(e.n)) e.s[i] = 1'b1;
        e.len = l;
        e.name = "rand";
        return e;
    endfunction

    task automatic apply(input string nm, input logic rst, input logic [3:0] t, input logic [3:0] u,
                         input logic [3:0] l, input logic [3:0] w, input logic [3:0] n, input logic [15:0] s);
        exp_t e;
        rst_n = rst; bus.tcode = t; bus.ulight = u; bus.lenght = l;
        e.w = w; e.n = n; e.s = s; e.len = l; e.name = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every output update is compared against the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, "_wshade"},   {12'd0, bus.wshade},   {12'd0, e.w});
                chk({e.name, "_lightnum"}, {12'd0, bus.lightnum}, {12'd0, e.n});
                chk({e.name, "_lightstate"}, bus.lightstate, e.s);
                chk({e.name, "_popcount"}, 16'($countones(bus.lightstate)), {12'd0, bus.lightnum});
                chk({e.name, "_le_len"}, {15'd0, (bus.lightnum <= e.len)}, 16'd1);
            end
        end
    end

    initial begin
        exp_t m;
        logic [3:0] t, u, l;
        int waited;
        apply("rst0", 1'b0, 4'b0001, 4'b1111, 4'b1111, 4'h0, 4'd0, 16'h0000);
        apply("rst1", 1'b0, 4'b0001, 4'b1111, 4'b1111, 4'h0, 4'd0, 16'h0000);
        apply("rel",  1'b1, 4'b0001, 4'b1111, 4'b1111, 4'h0, 4'd15, 16'h7FFF);
        apply("s4",   1'b1, 4'b0000, 4'b1001, 4'b1110, 4'hF, 4'd0, 16'h0000);
        apply("s0",   1'b1, 4'b0001, 4'b1001, 4'b1110, 4'h0, 4'd9, 16'h01FF);
        apply("s1",   1'b1, 4'b0010, 4'b0110, 4'b1010, 4'h4, 4'd6, 16'h003F);
        apply("cap6", 1'b1, 4'b0001, 4'b1100, 4'b0110, 4'h0, 4'd6, 16'h003F);
        apply("cap0", 1'b1, 4'b0010, 4'b1010, 4'b0000, 4'h4, 4'd0, 16'h0000);
        apply("s2",   1'b1, 4'b0100, 4'b1010, 4'b1000, 4'h8, 4'd5, 16'h001F);
        apply("s3",   1'b1, 4'b1000, 4'b1100, 4'b0110, 4'hC, 4'd3, 16'h0007);
        apply("prio", 1'b1, 4'b1010, 4'b1000, 4'b1111, 4'hC, 4'd2, 16'h0003);
        apply("prio2",1'b1, 4'b0110, 4'b1111, 4'b1111, 4'h8, 4'd7, 16'h007F);
        apply("s3lo", 1'b1, 4'b1111, 4'b0011, 4'b1111, 4'hC, 4'd0, 16'h0000);
        apply("max",  1'b1, 4'b0001, 4'b1111, 4'b1111, 4'h0, 4'd15, 16'h7FFF);
        apply("midrst",1'b0, 4'b0001, 4'b1111, 4'b1111, 4'h0, 4'd0, 16'h0000);
        apply("rel2", 1'b1, 4'b0010, 4'b0101, 4'b0011, 4'h4, 4'd3, 16'h0007);
        for (int i = 0; i < 200; i++) begin
            t = 4'($urandom_range(0, 15));
            u = 4'($urandom_range(0, 15));
            l = 4'($urandom_range(0, 15));
            m = model(t, u, l);
            apply("rand", 1'b1, t, u, l, m.w, m.n, m.s);
        end
        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
